// File: rtl/wave_reader.sv
// Waveform memory read initiator: a divided tick advances a phase accumulator
// that addresses a 1-clk-latency ROM; returned samples are presented with a strobe.
module wave_reader #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 12,
  parameter int PHASE_W = 24,
  parameter int DIV_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               phase_clr,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [DIV_W-1:0]   rate_div,
  output logic [ADDR_W-1:0]  address,
  input  logic [DATA_W-1:0]  sample_in,
  output logic [DATA_W-1:0]  sample_out,
  output logic               sample_valid
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [1:0]         pipe_q, pipe_d;
  logic [DATA_W-1:0]  sample_q, sample_d;
  logic               valid_q, valid_d;
  logic               tick;

  assign tick = enable & (div_q == rate_div);

  // A clear wins over a coincident tick: no increment and no read is issued.
  always_comb begin
    phase_d = phase_q;
    div_d   = div_q;
    addr_d  = addr_q;
    if (phase_clr) begin
      phase_d = '0;
      div_d   = '0;
      addr_d  = '0;
    end else if (tick) begin
      phase_d = phase_q + freq_word;
      div_d   = '0;
      addr_d  = phase_d[PHASE_W-1 -: ADDR_W];
    end else if (enable) begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // pipe_q[0]: address presented to memory; pipe_q[1]: memory data now valid.
  always_comb begin
    pipe_d   = {pipe_q[0], tick & ~phase_clr};
    valid_d  = pipe_q[1];
    sample_d = pipe_q[1] ? sample_in : sample_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= '0;
      div_q    <= '0;
      addr_q   <= '0;
      pipe_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      div_q    <= div_d;
      addr_q   <= addr_d;
      pipe_q   <= pipe_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign address      = addr_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;

endmodule
